// File: rtl/background_sequencer_pkg.sv
// rtl/background_sequencer_pkg.sv - shared scene types for the background renderer
package background_sequencer_pkg;

  typedef enum logic [1:0] {BG_DAY, BG_DUSK, BG_SUNSET, BG_NIGHT} bg_stage_t;

  localparam int BG_NUM_STAGES = 4;

  function automatic logic [BG_NUM_STAGES-1:0] bg_onehot(input bg_stage_t s);
    return {{(BG_NUM_STAGES-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/frame_dwell_counter.sv
// rtl/frame_dwell_counter.sv - saturating frame counter with dwell/attract compare flags
module frame_dwell_counter #(
  parameter int MIN_DWELL_FRAMES = 60,
  parameter int ATTRACT_FRAMES   = 300
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic ge_min,
  output logic ge_attract
);

  localparam int SAT = (MIN_DWELL_FRAMES > ATTRACT_FRAMES) ? MIN_DWELL_FRAMES : ATTRACT_FRAMES;
  localparam int W   = $clog2(SAT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && count != W'(SAT)) begin
      count <= count + 1'b1;
    end
  end

  // Integer compares keep a zero threshold from degenerating into an always-true unsigned test.
  always_comb begin
    ge_min     = int'(count) >= MIN_DWELL_FRAMES;
    ge_attract = int'(count) >= ATTRACT_FRAMES - 1;
  end

endmodule

// File: rtl/background_sequencer.sv
// rtl/background_sequencer.sv - picks the sky scene from score or attract timer, frame-aligned
module background_sequencer
  import background_sequencer_pkg::*;
#(
  parameter int POINTS_PER_STAGE = 3,
  parameter int MIN_DWELL_FRAMES = 60,
  parameter int ATTRACT_FRAMES   = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_done,
  input  logic       point_scored,
  input  logic       new_game,
  input  logic       attract,
  output logic       background_1,
  output logic       background_2,
  output logic       background_3,
  output logic       background_4,
  output logic [1:0] stage,
  output logic       stage_changed
);

  localparam int PT_W = $clog2(POINTS_PER_STAGE + 1);

  bg_stage_t                  stage_q;
  bg_stage_t                  stage_nxt;
  bg_stage_t                  target;
  logic [PT_W-1:0]            pt_cnt;
  logic                       clear_pend;
  logic [BG_NUM_STAGES-1:0]   bg_q;
  logic                       stage_changed_q;
  logic                       ge_min;
  logic                       ge_attract;
  logic                       do_clear;
  logic                       do_step;
  logic                       attract_step;

  frame_dwell_counter #(
    .MIN_DWELL_FRAMES(MIN_DWELL_FRAMES),
    .ATTRACT_FRAMES  (ATTRACT_FRAMES)
  ) u_dwell (
    .clock     (clock),
    .reset     (reset),
    .clear     (do_clear | do_step),
    .enable    (frame_done),
    .ge_min    (ge_min),
    .ge_attract(ge_attract)
  );

  // Scene decisions only on frame_done, highest priority first.
  always_comb begin
    do_clear     = 1'b0;
    do_step      = 1'b0;
    attract_step = 1'b0;
    stage_nxt    = stage_q;
    if (frame_done) begin
      if (clear_pend) begin
        do_clear  = 1'b1;
        stage_nxt = BG_DAY;
      end else if (attract && ge_attract) begin
        do_step      = 1'b1;
        attract_step = 1'b1;
        stage_nxt    = bg_stage_t'(stage_q + 2'd1);
      end else if (!attract && (stage_q < target) && ge_min) begin
        do_step   = 1'b1;
        stage_nxt = bg_stage_t'(stage_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q         <= BG_DAY;
      bg_q            <= bg_onehot(BG_DAY);
      stage_changed_q <= 1'b0;
      target          <= BG_DAY;
      pt_cnt          <= '0;
      clear_pend      <= 1'b0;
    end else begin
      stage_q         <= stage_nxt;
      bg_q            <= bg_onehot(stage_nxt);
      stage_changed_q <= (stage_nxt != stage_q);
      if (do_clear) clear_pend <= 1'b0;
      if (attract_step) target <= stage_nxt;
      // new_game is placed last so it overrides a same-cycle clear consumption.
      if (new_game) begin
        pt_cnt     <= '0;
        target     <= BG_DAY;
        clear_pend <= 1'b1;
      end else if (point_scored && !attract) begin
        if (pt_cnt == PT_W'(POINTS_PER_STAGE - 1)) begin
          pt_cnt <= '0;
          if (target != BG_NIGHT) target <= bg_stage_t'(target + 2'd1);
        end else begin
          pt_cnt <= pt_cnt + 1'b1;
        end
      end
    end
  end

  assign background_1  = bg_q[0];
  assign background_2  = bg_q[1];
  assign background_3  = bg_q[2];
  assign background_4  = bg_q[3];
  assign stage         = stage_q;
  assign stage_changed = stage_changed_q;

endmodule

// File: tb/tb_background_sequencer.sv
// tb/tb_background_sequencer.sv - self-checking bench for background_sequencer
module tb_background_sequencer;

  localparam int PPS = 3;
  localparam int MIN = 2;
  localparam int ATT = 4;
  localparam int SAT = (MIN > ATT) ? MIN : ATT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_done = 1'b0;
  logic       point_scored = 1'b0;
  logic       new_game = 1'b0;
  logic       attract = 1'b0;
  logic       background_1, background_2, background_3, background_4;
  logic [1:0] stage;
  logic       stage_changed;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int m_stage  = 0;
  int m_target = 0;
  int m_pts    = 0;
  int m_dwell  = 0;
  int m_clear  = 0;
  int m_pulse  = 0;

  background_sequencer #(
    .POINTS_PER_STAGE(PPS),
    .MIN_DWELL_FRAMES(MIN),
    .ATTRACT_FRAMES  (ATT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_done   (frame_done),
    .point_scored (point_scored),
    .new_game     (new_game),
    .attract      (attract),
    .background_1 (background_1),
    .background_2 (background_2),
    .background_3 (background_3),
    .background_4 (background_4),
    .stage        (stage),
    .stage_changed(stage_changed)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scene rules applied to the pre-edge state of one clock cycle.
  task automatic model_step(input bit rst, input bit fd, input bit ps, input bit ng, input bit at);
    int old_stage;
    int old_target;
    old_stage  = m_stage;
    old_target = m_target;
    if (rst) begin
      m_stage = 0; m_target = 0; m_pts = 0; m_dwell = 0; m_clear = 0; m_pulse = 0;
      return;
    end
    if (fd) begin
      if (m_clear != 0) begin
        m_stage = 0; m_dwell = 0; m_clear = 0;
      end else if (at && m_dwell >= ATT - 1) begin
        m_stage = (m_stage + 1) % 4; m_target = m_stage; m_dwell = 0;
      end else if (!at && old_stage < old_target && m_dwell >= MIN) begin
        m_stage = m_stage + 1; m_dwell = 0;
      end else if (m_dwell < SAT) begin
        m_dwell = m_dwell + 1;
      end
    end
    if (ng) begin
      m_pts = 0; m_target = 0; m_clear = 1;
    end else if (ps && !at) begin
      m_pts = m_pts + 1;
      if (m_pts == PPS) begin
        m_pts = 0;
        if (m_target < 3) m_target = m_target + 1;
      end
    end
    m_pulse = (m_stage != old_stage) ? 1 : 0;
  endtask

  task automatic tick(input bit rst, input bit fd, input bit ps, input bit ng, input bit at);
    reset = rst; frame_done = fd; point_scored = ps; new_game = ng; attract = at;
    @(posedge clock);
    model_step(rst, fd, ps, ng, at);
    @(negedge clock);
    reset = 1'b0; frame_done = 1'b0; point_scored = 1'b0; new_game = 1'b0;
  endtask

  task automatic frame(input bit at);
    tick(0, 1, 0, 0, at);
    tick(0, 0, 0, 0, at);
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0, 0);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("stage", int'(stage), m_stage);
      check("bg_onehot", int'({background_4, background_3, background_2, background_1}), 1 << m_stage);
      check("stage_changed", int'(stage_changed), m_pulse);
    end
  end

  initial begin
    // 1: reset, then idle frames keep day
    tick(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    tick(1, 0, 0, 0, 0);
    check("rst_stage", int'(stage), 0);
    check("rst_bg1", int'(background_1), 1);
    check("rst_bg234", int'({background_4, background_3, background_2}), 0);
    check("rst_pulse", int'(stage_changed), 0);
    for (int i = 0; i < 10; i++) frame(0);
    check("t1_idle_stage", int'(stage), 0);

    // 2: three points, step on third frame
    tick(1, 0, 0, 0, 0);
    points(3);
    frame(0);
    frame(0);
    check("t2_fd2_stage", int'(stage), 0);
    tick(0, 1, 0, 0, 0);
    check("t2_fd3_stage", int'(stage), 1);
    check("t2_fd3_bg2", int'(background_2), 1);
    check("t2_fd3_pulse", int'(stage_changed), 1);
    tick(0, 0, 0, 0, 0);
    check("t2_pulse_drop", int'(stage_changed), 0);

    // 3: twelve-point burst, steps on frames 3, 6, 9 then holds
    tick(1, 0, 0, 0, 0);
    points(12);
    for (int i = 1; i <= 12; i++) begin
      frame(0);
      if (i == 3) check("t3_fd3", int'(stage), 1);
      if (i == 6) check("t3_fd6", int'(stage), 2);
      if (i == 9) check("t3_fd9", int'(stage), 3);
    end
    check("t3_hold", int'(stage), 3);
    check("t3_target", int'(dut.target), 3);

    // 4: attract cycling with ignored points
    tick(1, 0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 1, 0, 0, 1);
      if (i % 4 == 0) check("t4_attract_stage", int'(stage), (i / 4) % 4);
      tick(0, 0, 1, 0, 1);
    end
    check("t4_target", int'(dut.target), 0);

    // 5: new_game + point + frame in one cycle at stage 3
    tick(1, 0, 0, 0, 0);
    points(9);
    for (int i = 0; i < 9; i++) frame(0);
    check("t5_at_night", int'(stage), 3);
    tick(0, 1, 1, 1, 0);
    check("t5_hold", int'(stage), 3);
    check("t5_no_pulse", int'(stage_changed), 0);
    tick(0, 1, 0, 0, 0);
    check("t5_clear_stage", int'(stage), 0);
    check("t5_clear_pulse", int'(stage_changed), 1);
    check("t5_target", int'(dut.target), 0);
    for (int i = 0; i < 5; i++) frame(0);
    check("t5_stays_day", int'(stage), 0);

    // 6: reset with pending clear and raised target
    tick(1, 0, 0, 0, 0);
    points(6);
    for (int i = 0; i < 3; i++) frame(0);
    tick(0, 0, 0, 1, 0);
    points(6);
    check("t6_pre_stage", int'(stage), 1);
    tick(1, 0, 0, 0, 0);
    check("t6_rst_stage", int'(stage), 0);
    check("t6_rst_pulse", int'(stage_changed), 0);
    tick(0, 1, 0, 0, 0);
    check("t6_fd_stage", int'(stage), 0);
    check("t6_fd_pulse", int'(stage_changed), 0);
    tick(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
